gemm_ws_stream: RTL and testbench
=================================

# gemm_ws_stream

Weight-stationary INT-N GEMM engine with streaming valid/ready handshakes. It holds an SA_SIZE x SA_SIZE signed weight matrix, accepts one activation vector per cycle, and emits one aligned accumulator-width result vector per input vector. It contains its own input skew, PE grid and output de-skew. It adds weight loading, backpressure stalls, bubble tracking and end-of-batch drain, and sits between the activation buffer and the result writeback.

## Interface
- SA_SIZE, 4: array rows/columns; >= 2
- WEIGHT_SIZE, 8: signed weight width
- ACTIVATION_SIZE, 8: signed activation width
- ACC_SIZE, WEIGHT_SIZE+ACTIVATION_SIZE+$clog2(SA_SIZE): signed result width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin batch; honoured only in IDLE
- w_valid  in  1  weight row write strobe
- w_ready  out  1  high only in IDLE
- w_row  in  $clog2(SA_SIZE)  row index i
- w_data  in  [SA_SIZE] x WEIGHT_SIZE  W[i][0..SA_SIZE-1]
- in_valid / in_ready  in / out  1  activation handshake
- in_last  in  1  marks final vector of batch
- in_data  in  [SA_SIZE] x ACTIVATION_SIZE  a[0..SA_SIZE-1]
- out_valid / out_ready  out / in  1  result handshake
- out_last  out  1  result of the in_last vector
- out_data  out  [SA_SIZE] x ACC_SIZE  y[0..SA_SIZE-1]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when DRAIN completes

## Operation
- Function: y[j] = sum_i a[i]*W[i][j], signed; products sign-extended to ACC_SIZE; sums wrap modulo 2^ACC_SIZE.
- Weight write: w_valid && w_ready -> W[w_row] <= w_data at that edge; ignored outside IDLE.
- FSM states: IDLE, COMPUTE, DRAIN.
  - IDLE -> COMPUTE on start.
  - COMPUTE -> DRAIN on accepted vector with in_last.
  - DRAIN -> IDLE when no valid token remains in the pipeline and the output is empty; done=1 for that cycle.
- start outside IDLE: ignored.
- start and w_valid in the same IDLE cycle: the write lands; the batch uses the new weights.
- in_ready = (state==COMPUTE) && !stall.
- Accepted vector: skew-in delays row i by i cycles. Activations move right one PE per cycle; partial sums move down one PE per cycle. De-skew delays column j by SA_SIZE-1-j.
- Bubbles: a cycle with no accepted vector in COMPUTE/DRAIN injects zeros with an invalid token. Bubbles never produce out_valid.
- Token/last tracking: 2*SA_SIZE-deep shift register of {valid,last}, advancing only when not stalled.
- stall = out_valid && !out_ready. While stalled, every pipeline register (skew, PEs, de-skew, tokens) holds, and out_data/out_last stay stable.
- Reset (any time, including mid-batch): state IDLE, weights 0, all pipeline and token registers 0. In-flight vectors are discarded with no done pulse.

## Timing
- Reset values: w_ready=1, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
- Latency: a vector accepted at edge k presents out_valid=1 with its result after edge k+2*SA_SIZE, absent stalls. Each stalled cycle adds exactly one cycle.
- Throughput: 1 vector/cycle while out_ready is held high.
- in_ready drops combinationally in the same cycle out_valid && !out_ready is true.
- done asserts the cycle after the out_last transfer completes, at the earliest.
- Empty batch is impossible: start followed by in_last on the first vector gives exactly one result, then done.

## Test plan
- Identity W, SA_SIZE=4; stream [1,2,3,4], [-1,-2,-3,-4] with out_ready=1 -> the same vectors appear at edges k+8 and k+9; out_last on the second; done one cycle after.
- All W=-128, a=[-128,-128,-128,-128] -> every y[j]=65536 (ACC_SIZE=18). Set ACC_SIZE=16 -> y[j]=0 (wrap).
- 20 back-to-back random vectors; out_ready toggled in a pseudo-random pattern -> results match the golden model in order, none dropped or duplicated, out_data stable while stalled.
- in_valid pattern 1,0,0,1 with W[i][j]=i+j -> exactly two results; output gaps match the input gaps.
- w_valid during COMPUTE (row 0 set to all 7s) -> W unchanged, results unaffected, w_ready=0.
- Reset asserted 3 cycles after the 2nd accepted vector -> all outputs immediately at reset values, no out_valid, no done. A new batch after release works from zeroed weights.

Source files
------------

// File: rtl/gemm_ws_stream.sv
// gemm_ws_stream: weight-stationary systolic GEMM with input skew, PE grid, output de-skew and streaming handshakes
module gemm_ws_stream #(
    parameter int SA_SIZE = 4,
    parameter int WEIGHT_SIZE = 8,
    parameter int ACTIVATION_SIZE = 8,
    parameter int ACC_SIZE = WEIGHT_SIZE + ACTIVATION_SIZE + $clog2(SA_SIZE)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 start_i,
    input  logic                                 w_valid_i,
    output logic                                 w_ready_o,
    input  logic [$clog2(SA_SIZE)-1:0]           w_row_i,
    input  logic [SA_SIZE*WEIGHT_SIZE-1:0]       w_data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic                                 in_last_i,
    input  logic [SA_SIZE*ACTIVATION_SIZE-1:0]   in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic                                 out_last_o,
    output logic [SA_SIZE*ACC_SIZE-1:0]          out_data_o,
    output logic                                 busy_o,
    output logic                                 done_o
);
    localparam int N = SA_SIZE;
    localparam int WS = WEIGHT_SIZE;
    localparam int AS = ACTIVATION_SIZE;
    localparam int CS = ACC_SIZE;
    localparam int D = 2 * N;
    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;
    state_t state_q;
    logic signed [WS-1:0] w_q [N][N];
    logic signed [AS-1:0] a_w [N][N];
    logic signed [AS-1:0] act_q [N][N-1];
    logic signed [CS-1:0] p_w [N][N];
    logic signed [CS-1:0] ps_q [N][N];
    logic signed [CS-1:0] col_y [N];
    logic [D-1:0] tok_v_q, tok_l_q;
    logic out_valid_q, out_last_q, done_q;
    logic [N*CS-1:0] out_data_q;
    logic stall, acc_in, drained;

    assign stall = out_valid_q && !out_ready_i;
    assign in_ready_o = (state_q == COMPUTE) && !stall;
    assign acc_in = in_valid_i && in_ready_o;
    assign drained = !(|tok_v_q) && (!out_valid_q || out_ready_i);
    assign w_ready_o = state_q == IDLE;
    assign busy_o = state_q != IDLE;
    assign done_o = done_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o = out_last_q;
    assign out_data_o = out_data_q;

    // Weight rows are writable only while idle
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) w_q[i][j] <= '0;
        end else if (w_valid_i && w_ready_o) begin
            for (int j = 0; j < N; j++) w_q[w_row_i][j] <= w_data_i[j*WS +: WS];
        end

    for (genvar i = 0; i < N; i++) begin : g_row
        logic signed [AS-1:0] sk_q [i+1];
        // Row i enters the grid i+1 cycles after acceptance; bubbles inject zeros
        always_ff @(posedge clk_i or posedge reset_i)
            if (reset_i) begin
                for (int d = 0; d <= i; d++) sk_q[d] <= '0;
            end else if (!stall) begin
                sk_q[0] <= acc_in ? in_data_i[i*AS +: AS] : '0;
                for (int d = 1; d <= i; d++) sk_q[d] <= sk_q[d-1];
            end
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_l
                assign a_w[i][j] = sk_q[i];
            end else begin : g_r
                assign a_w[i][j] = act_q[i][j-1];
            end
            if (i == 0) begin : g_t
                assign p_w[i][j] = '0;
            end else begin : g_d
                assign p_w[i][j] = ps_q[i-1][j];
            end
        end
    end

    // PE grid: activations shift right, partial sums shift down, both frozen on stall
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) ps_q[i][j] <= '0;
            for (int i = 0; i < N; i++) for (int j = 0; j < N - 1; j++) act_q[i][j] <= '0;
        end else if (!stall) begin
            for (int i = 0; i < N; i++) for (int j = 0; j < N; j++)
                ps_q[i][j] <= p_w[i][j] + CS'(a_w[i][j]) * CS'(w_q[i][j]);
            for (int i = 0; i < N; i++) for (int j = 0; j < N - 1; j++) act_q[i][j] <= a_w[i][j];
        end

    for (genvar j = 0; j < N; j++) begin : g_dsk
        if (j == N - 1) begin : g_pass
            assign col_y[j] = ps_q[N-1][j];
        end else begin : g_dly
            logic signed [CS-1:0] dk_q [N-1-j];
            // Column j waits N-1-j cycles so all columns of one vector line up
            always_ff @(posedge clk_i or posedge reset_i)
                if (reset_i) begin
                    for (int d = 0; d < N - 1 - j; d++) dk_q[d] <= '0;
                end else if (!stall) begin
                    dk_q[0] <= ps_q[N-1][j];
                    for (int d = 1; d < N - 1 - j; d++) dk_q[d] <= dk_q[d-1];
                end
            assign col_y[j] = dk_q[N-2-j];
        end
    end

    // Token chain tracks valid/last alongside the data and loads the output register
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            tok_v_q <= '0;
            tok_l_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else if (!stall) begin
            tok_v_q <= {tok_v_q[D-2:0], acc_in};
            tok_l_q <= {tok_l_q[D-2:0], acc_in && in_last_i};
            out_valid_q <= tok_v_q[D-1];
            out_last_q <= tok_l_q[D-1];
            for (int j = 0; j < N; j++) out_data_q[j*CS +: CS] <= col_y[j];
        end

    // Batch FSM; done pulses as the pipeline and output register become empty
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && drained;
            if (state_q == IDLE && start_i) state_q <= COMPUTE;
            else if (state_q == COMPUTE && acc_in && in_last_i) state_q <= DRAIN;
            else if (state_q == DRAIN && drained) state_q <= IDLE;
        end
endmodule

// File: tb/tb_gemm_ws_stream.sv
// tb_gemm_ws_stream: directed bench with scoreboard for gemm_ws_stream
module tb_gemm_ws_stream;
    localparam int N = 4;
    typedef struct {
        logic [127:0] d;
        logic [127:0] d16;
        logic l;
        int k;
    } exp_t;
    logic clk_i = 0, reset_i = 1, start_i = 0, w_valid_i = 0;
    logic [1:0] w_row_i = 0;
    logic [31:0] w_data_i = 0, in_data_i = 0;
    logic in_valid_i = 0, in_last_i = 0, out_ready_i = 1;
    logic w_ready_o, in_ready_o, out_valid_o, out_last_o, busy_o, done_o;
    logic [71:0] out_data_o;
    logic w16_ready, in16_ready, out16_valid, out16_last, busy16, done16;
    logic [63:0] out16_data;
    logic signed [7:0] wm [N][N];
    exp_t sbq [$];
    int pass_n = 0, tot_n = 0, cyc = 0, n_out = 0, n_done = 0, last_cyc = -1, done_cyc = -2;
    bit chk_lat = 0, rand_rdy = 0, was_stall = 0;
    logic [71:0] held_d;
    logic held_l;

    gemm_ws_stream dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .w_valid_i(w_valid_i),
        .w_ready_o(w_ready_o), .w_row_i(w_row_i), .w_data_i(w_data_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_last_i(in_last_i),
        .in_data_i(in_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o), .out_data_o(out_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    gemm_ws_stream #(.ACC_SIZE(16)) dut16 (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .w_valid_i(w_valid_i),
        .w_ready_o(w16_ready), .w_row_i(w_row_i), .w_data_i(w_data_i),
        .in_valid_i(in_valid_i), .in_ready_o(in16_ready), .in_last_i(in_last_i),
        .in_data_i(in_data_i), .out_valid_o(out16_valid), .out_ready_i(out_ready_i),
        .out_last_o(out16_last), .out_data_o(out16_data), .busy_o(busy16), .done_o(done16)
    );

    initial forever #5 clk_i = ~clk_i;
    initial forever begin @(posedge clk_i); cyc++; end
    initial forever begin
        @(posedge clk_i);
        #1;
        out_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tot_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] gold(input logic [31:0] av, input int aw);
        logic [127:0] r = '0;
        for (int j = 0; j < N; j++) begin
            int s = 0;
            for (int i = 0; i < N; i++) s += int'($signed(av[i*8 +: 8])) * int'(wm[i][j]);
            for (int b = 0; b < aw; b++) r[j*aw + b] = s[b];
        end
        return r;
    endfunction

    task automatic wr(input int r, input logic [31:0] v, input logic exp_rdy);
        w_valid_i = 1;
        w_row_i = 2'(r);
        w_data_i = v;
        @(negedge clk_i);
        chk("w_ready", w_ready_o, exp_rdy);
        @(posedge clk_i);
        #1;
        w_valid_i = 0;
        if (exp_rdy) for (int j = 0; j < N; j++) wm[r][j] = v[j*8 +: 8];
    endtask

    task automatic begin_batch();
        start_i = 1;
        @(posedge clk_i);
        #1;
        start_i = 0;
    endtask

    task automatic send(input logic [31:0] av, input logic last);
        exp_t e;
        in_valid_i = 1;
        in_last_i = last;
        in_data_i = av;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                e.d = gold(av, 18);
                e.d16 = gold(av, 16);
                e.l = last;
                e.k = cyc + 1;
                sbq.push_back(e);
                @(posedge clk_i);
                #1;
                in_valid_i = 0;
                in_last_i = 0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 0;
        chk("send_timeout", in_ready_o, 1'b1);
    endtask

    task automatic wait_idle(input int prev_done);
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk_i);
            if (!busy_o) break;
        end
        @(posedge clk_i);
        #1;
        chk("idle_reached", busy_o, 1'b0);
        chk("done_count", n_done, prev_done + 1);
        chk("done_after_last", done_cyc, last_cyc + 1);
        chk("done_pulse", done_o, 1'b0);
    endtask

    // Output monitor: pops the scoreboard on each transfer and checks stall stability
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                chk("valid16", out16_valid, out_valid_o);
                if (was_stall) begin
                    chk("stable_valid", out_valid_o, 1'b1);
                    chk("stable_data", out_data_o, held_d);
                    chk("stable_last", out_last_o, held_l);
                end
                if (out_valid_o && !out_ready_i) chk("in_ready_stall", in_ready_o, 1'b0);
                if (out_valid_o && out_ready_i) begin
                    if (sbq.size() == 0) chk("unexpected_out", out_valid_o, 1'b0);
                    else begin
                        e = sbq.pop_front();
                        chk("data", out_data_o, e.d);
                        chk("data16", out16_data, e.d16);
                        chk("last", out_last_o, e.l);
                        if (chk_lat) chk("latency", cyc, e.k + 2 * N);
                        n_out++;
                        if (out_last_o) last_cyc = cyc;
                    end
                end
                if (done_o) begin
                    n_done++;
                    done_cyc = cyc;
                end
                was_stall = out_valid_o && !out_ready_i;
                held_d = out_data_o;
                held_l = out_last_o;
            end else was_stall = 0;
        end
    end

    initial begin
        int n0, nd;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_w_ready", w_ready_o, 1'b1);
        chk("rst_in_ready", in_ready_o, 1'b0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_out_last", out_last_o, 1'b0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        reset_i = 0;
        @(posedge clk_i);
        #1;
        // identity weights, two back-to-back vectors
        chk_lat = 1;
        for (int r = 0; r < N; r++) wr(r, 32'h1 << (8 * r), 1'b1);
        begin_batch();
        chk("busy_compute", busy_o, 1'b1);
        send(32'h04030201, 1'b0);
        send(32'hFCFDFEFF, 1'b1);
        wait_idle(n_done);
        // all -128: 65536 at 18 bits, wraps to 0 at 16 bits; last row written with start
        for (int r = 0; r < N - 1; r++) wr(r, 32'h80808080, 1'b1);
        w_valid_i = 1;
        w_row_i = 2'(N - 1);
        w_data_i = 32'h80808080;
        start_i = 1;
        @(posedge clk_i);
        #1;
        w_valid_i = 0;
        start_i = 0;
        for (int j = 0; j < N; j++) wm[N-1][j] = -8'sd128;
        send(32'h80808080, 1'b1);
        wait_idle(n_done);
        // bubbles: in_valid 1,0,0,1 with W[i][j]=i+j
        for (int r = 0; r < N; r++) wr(r, {8'(r + 3), 8'(r + 2), 8'(r + 1), 8'(r)}, 1'b1);
        begin_batch();
        n0 = n_out;
        send(32'h05FD0702, 1'b0);
        repeat (2) begin @(posedge clk_i); #1; end
        send(32'hF9030BFE, 1'b1);
        wait_idle(n_done);
        chk("bubble_count", n_out - n0, 2);
        // weight write during COMPUTE is ignored
        begin_batch();
        send(32'h01020304, 1'b0);
        wr(0, 32'h07070707, 1'b0);
        send(32'h11F0220E, 1'b1);
        wait_idle(n_done);
        // random weights and data with random backpressure
        chk_lat = 0;
        for (int r = 0; r < N; r++) wr(r, $urandom, 1'b1);
        begin_batch();
        rand_rdy = 1;
        n0 = n_out;
        for (int k = 0; k < 20; k++) send($urandom, k == 19);
        wait_idle(n_done);
        rand_rdy = 0;
        chk("rand_count", n_out - n0, 20);
        chk("rand_sb_empty", sbq.size(), 0);
        // reset mid-batch
        chk_lat = 1;
        begin_batch();
        send(32'h01010101, 1'b0);
        send(32'h02020202, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        nd = n_done;
        reset_i = 1;
        #1;
        chk("mid_rst_out_valid", out_valid_o, 1'b0);
        chk("mid_rst_out_last", out_last_o, 1'b0);
        chk("mid_rst_out_data", out_data_o, 0);
        chk("mid_rst_w_ready", w_ready_o, 1'b1);
        chk("mid_rst_in_ready", in_ready_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_done", done_o, 1'b0);
        sbq.delete();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 0;
        repeat (12) begin @(posedge clk_i); #1; end
        chk("no_done_after_reset", n_done, nd);
        begin_batch();
        send(32'h7F80057B, 1'b1);
        wait_idle(nd);
        chk("final_sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
